store_write_buffer: RTL
=======================

# store_write_buffer

Post-commit store buffer between the store queue's dcache port and the data-cache write port. It accepts up to `NUM_SQ_DCACHE` committed stores per cycle, converts each into a word-aligned write with a byte mask, and holds them in a FIFO. It drains one write per cycle to the cache under a valid/ready handshake. It also answers combinational load-forwarding lookups so loads observe stores that have left the store queue but are not yet in the cache.

## Interface
Parameters:
- `WB_LEN`, 4: number of buffer entries.
- `WB_IN`, `` `NUM_SQ_DCACHE ``: store-queue packets offered per cycle.
- `WB_LOOKUP`, `` `NUM_FU_LOAD ``: number of load-forwarding lookup ports.

Ports:
- `clock`  in  1: single clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-low.
- `sq_dcache_packet`  in  `WB_IN`×`SQ_DCACHE_PACKET`: `{valid, addr, sign_size, data}`; data is unaligned, in the low bits.
- `dcache_accept`  out  `WB_IN`: per-slot accept back to the store queue.
- `wb_mem_req`  out  `WB_MEM_PACKET`: `{valid, addr (word-aligned), data, mask[3:0]}`.
- `mem_ready`  in  1: cache write port ready.
- `lq_addr`  in  `WB_LOOKUP`×`ADDR`: load lookup addresses.
- `fwd_data`  out  `WB_LOOKUP`×`DATA`: word-aligned forwarded bytes.
- `fwd_mask`  out  `WB_LOOKUP`×4: lanes supplied by `fwd_data`.
- `wb_empty`  out  1: high when count is 0.
- `wb_count`  out  `$clog2(WB_LEN+1)`: current occupancy.

## Operation
- **Lane conversion.** Size is `sign_size[1:0]`.
  - BYTE: mask is `1<<addr[1:0]`; `data[7:0]` is replicated to that lane.
  - HALF: mask is `4'b0011<<{addr[1],1'b0}`; `data[15:0]` goes to the selected half.
  - WORD: mask is `4'b1111`.
  - Misaligned HALF or WORD is unsupported, and the bench never drives it.
  - Stored address is `{addr[31:2],2'b00}`.
- **Accept.**
  - `dcache_accept[i]` = `valid[i]` && `dcache_accept[i-1]` (true for i=0) && `i < free`.
  - `free` = `WB_LEN - count` from registered state only. There is no same-cycle credit from a pop.
  - Invalid slots stop the prefix.
  - Accepted packets are enqueued in slot order at the tail.
- **Drain.**
  - `wb_mem_req.valid` = `count != 0`; the payload is the head entry.
  - Transfer happens when `valid && mem_ready`; the head pops at that posedge.
  - The payload must stay stable while `valid && !mem_ready`.
- **Head/tail.** Indices wrap modulo `WB_LEN`. A full buffer is distinguished from empty by `count`.
- **Simultaneous push and pop.** Both apply, and `count += accepted - popped`.
- **Forwarding.**
  - For each lookup, scan entries oldest to youngest.
  - Every entry whose word address matches `lq_addr[31:2]` overwrites its masked lanes, so the youngest store wins per byte.
  - `fwd_mask` is the OR of the matching masks. Unsupplied lanes of `fwd_data` are 0.
  - Packets arriving in the same cycle are not visible to the lookup.
  - An entry popping this cycle is still visible to the lookup.
- **No squash input.** All stores are committed and non-speculative.

## Timing
- `dcache_accept` and forwarding are combinational from registered state plus inputs. No output depends on `mem_ready` combinationally except through next state.
- Latency:
  - An accepted store is visible to lookups one cycle later.
  - It is presented on `wb_mem_req` one cycle later if the buffer was empty.
- Throughput: one drain per cycle; up to `WB_IN` pushes per cycle.
- Reset (`reset==0` at posedge):
  - `count`, head and tail all return to 0, and all entries are cleared.
  - Outputs: `wb_mem_req` = 0, `dcache_accept` = 0 for any input, `fwd_mask` = 0, `fwd_data` = 0, `wb_empty` = 1.
  - An in-flight request is dropped without waiting for `mem_ready`.

## Configuration
- **`WB_COALESCE_EN` defined.**
  - An incoming store whose word address equals the youngest valid entry's merges into that entry: its mask is ORed and its lanes are overwritten.
  - A merge consumes no slot and is accepted even when full.
  - No merge occurs into the head entry while `wb_mem_req.valid && mem_ready`.
  - Stores in the same cycle may chain-merge.
- **`WB_COALESCE_EN` undefined.** Every accepted store takes its own entry.

## Structure
- The shared package (`sys_defs.svh`) holds:
  - the `WB_MEM_PACKET` typedef;
  - `` `WB_LEN `` as the default;
  - a `WB_ENTRY` typedef `{valid, addr, data, mask}`.
- A single sub-module, `store_lane_align`, is natural. It is combinational: it maps `{addr, sign_size, data}` to `{aligned data, mask}`.

## Test plan
- **Reset.** Hold `reset=0` with valid packets and `mem_ready=1`. Required: `dcache_accept=0`, `wb_mem_req.valid=0`, `wb_empty=1`.
- **Single store.** SB to `0x1003`, data `0xAB`, `mem_ready=1`. Required: accept=1; next cycle `wb_mem_req` = `{1, 0x1000, 0xAB000000, 4'b1000}`, popped at that edge; `wb_empty=1` after.
- **Fill and backpressure.** `WB_LEN=4`, `mem_ready=0`, two stores per cycle for 3 cycles. Required: `dcache_accept` = 11, 11, 00; count=4; the `wb_mem_req` payload stays stable; raising `mem_ready` drains 4 writes in order on 4 consecutive cycles.
- **Forwarding, youngest wins.**
  - Stimulus: SW `0x2000`=`0x11223344`, then SH `0x2002`=`0xBEEF`, drain stalled.
  - Required: lookup `0x2001` gives `fwd_data=0xBEEF3344`, `fwd_mask=4'b1111`.
  - Required: lookup `0x3000` gives mask 0.
- **Wrap-around with simultaneous push/pop.** Run 20 cycles of 1 push and 1 pop per cycle with `mem_ready=1`. Required: writes emerge in push order across the index wrap; count is constant.
- **Coalescing (`WB_COALESCE_EN` defined).** SB `0x40` and SB `0x41` in the same cycle with the buffer stalled. Required: count=1, mask `4'b0011`; the undefined build gives count=2.

Source files
------------

// File: rtl/store_write_buffer_pkg.sv
// Shared types and defaults for the post-commit store write buffer.
// Packet layouts, size encoding and a byte-lane merge helper.
package store_write_buffer_pkg;

  localparam int NUM_SQ_DCACHE = 2;
  localparam int NUM_FU_LOAD   = 2;
  localparam int WB_LEN_DEF    = 4;

  typedef enum logic [1:0] {
    MEM_BYTE   = 2'b00,
    MEM_HALF   = 2'b01,
    MEM_WORD   = 2'b10,
    MEM_DOUBLE = 2'b11
  } mem_size_e;

  // sign_size[2] is the load sign flag; stores only use the size bits
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  sign_size;
    logic [31:0] data;
  } sq_dcache_packet_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wb_mem_packet_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wb_entry_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  mask);
    merge_lanes = old_data;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) merge_lanes[8*b +: 8] = new_data[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/store_write_buffer_lane_align.sv
// Moves unaligned store data into its word lanes and builds the byte mask.
// Purely combinational; lanes outside the mask are zero.
module store_write_buffer_lane_align
  import store_write_buffer_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] aligned,
  output logic [3:0]  mask
);

  always_comb begin
    aligned = data;
    mask    = 4'b1111;
    case (mem_size_e'(size))
      MEM_BYTE: begin
        mask    = 4'b0001 << offset;
        aligned = {24'h0, data[7:0]} << {offset, 3'b000};
      end
      MEM_HALF: begin
        mask    = 4'b0011 << {offset[1], 1'b0};
        aligned = {16'h0, data[15:0]} << {offset[1], 4'b0000};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// Post-commit store FIFO: accepts committed stores, drains one write per cycle, forwards to loads.
// Optional same-word merging into the youngest entry when WB_COALESCE_EN is defined.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int WB_LEN    = WB_LEN_DEF,
  parameter int WB_IN     = NUM_SQ_DCACHE,
  parameter int WB_LOOKUP = NUM_FU_LOAD
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  sq_dcache_packet_t [WB_IN-1:0]        sq_dcache_packet,
  output logic [WB_IN-1:0]                     dcache_accept,
  output wb_mem_packet_t                       wb_mem_req,
  input  logic                                 mem_ready,
  input  logic [WB_LOOKUP-1:0][31:0]           lq_addr,
  output logic [WB_LOOKUP-1:0][31:0]           fwd_data,
  output logic [WB_LOOKUP-1:0][3:0]            fwd_mask,
  output logic                                 wb_empty,
  output logic [$clog2(WB_LEN+1)-1:0]          wb_count
);

  localparam int IDX_W = (WB_LEN > 1) ? $clog2(WB_LEN) : 1;
  localparam int CNT_W = $clog2(WB_LEN+1);

  wb_entry_t          entries   [WB_LEN];
  wb_entry_t          entries_n [WB_LEN];
  logic [IDX_W-1:0]   head, head_n, tail, tail_n, slot_idx, fwd_idx;
  logic [CNT_W-1:0]   count, count_n;
  logic [WB_IN-1:0]   acc;
  logic               pop, prefix, slot_merge;
  int                 alloc, free;
  sq_dcache_packet_t  pkt;
  logic [WB_IN-1:0][31:0] al_data;
  logic [WB_IN-1:0][3:0]  al_mask;
  logic               unused_bits;
`ifdef WB_COALESCE_EN
  logic               young_vld;
  logic [IDX_W-1:0]   young_idx;
`endif

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    return IDX_W'((int'(base) + off) % WB_LEN);
  endfunction

  for (genvar g = 0; g < WB_IN; g++) begin : g_align
    store_write_buffer_lane_align u_align (
      .offset  (sq_dcache_packet[g].addr[1:0]),
      .size    (sq_dcache_packet[g].sign_size[1:0]),
      .data    (sq_dcache_packet[g].data),
      .aligned (al_data[g]),
      .mask    (al_mask[g])
    );
  end

  // Accept/enqueue: credit comes from registered occupancy only, never from this cycle's pop
  always_comb begin
    entries_n  = entries;
    acc        = '0;
    alloc      = 0;
    prefix     = 1'b1;
    slot_merge = 1'b0;
    slot_idx   = '0;
    pkt        = '0;
    pop        = (count != '0) && mem_ready;
    free       = WB_LEN - int'(count);
`ifdef WB_COALESCE_EN
    // A lone head that is leaving this cycle cannot absorb a merge
    young_vld  = (count != '0) && !(pop && count == CNT_W'(1));
    young_idx  = wrap_add(tail, WB_LEN - 1);
`endif
    if (pop) entries_n[head] = '0;
    for (int i = 0; i < WB_IN; i++) begin
      pkt = sq_dcache_packet[i];
`ifdef WB_COALESCE_EN
      slot_merge = young_vld && (entries_n[young_idx].addr[31:2] == pkt.addr[31:2]);
`endif
      if (prefix && pkt.valid && (slot_merge || alloc < free)) begin
        acc[i] = 1'b1;
        if (slot_merge) begin
`ifdef WB_COALESCE_EN
          entries_n[young_idx].data = merge_lanes(entries_n[young_idx].data, al_data[i], al_mask[i]);
          entries_n[young_idx].mask = entries_n[young_idx].mask | al_mask[i];
`endif
        end else begin
          slot_idx = wrap_add(tail, alloc);
          entries_n[slot_idx].valid = 1'b1;
          entries_n[slot_idx].addr  = {pkt.addr[31:2], 2'b00};
          entries_n[slot_idx].data  = al_data[i];
          entries_n[slot_idx].mask  = al_mask[i];
`ifdef WB_COALESCE_EN
          young_idx = slot_idx;
          young_vld = 1'b1;
`endif
          alloc = alloc + 1;
        end
      end else begin
        prefix = 1'b0;
      end
    end
    count_n = CNT_W'(int'(count) + alloc - int'(pop));
    tail_n  = wrap_add(tail, alloc);
    head_n  = pop ? wrap_add(head, 1) : head;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int k = 0; k < WB_LEN; k++) entries[k] <= '0;
    end else begin
      head    <= head_n;
      tail    <= tail_n;
      count   <= count_n;
      entries <= entries_n;
    end
  end

  // Oldest-to-youngest scan so later stores overwrite earlier ones per byte
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    fwd_idx  = '0;
    if (reset) begin
      for (int l = 0; l < WB_LOOKUP; l++) begin
        for (int k = 0; k < WB_LEN; k++) begin
          fwd_idx = wrap_add(head, k);
          if (entries[fwd_idx].valid && entries[fwd_idx].addr[31:2] == lq_addr[l][31:2]) begin
            for (int b = 0; b < 4; b++) begin
              if (entries[fwd_idx].mask[b]) fwd_data[l][8*b +: 8] = entries[fwd_idx].data[8*b +: 8];
            end
            fwd_mask[l] = fwd_mask[l] | entries[fwd_idx].mask;
          end
        end
      end
    end
  end

  always_comb begin
    wb_mem_req = '0;
    if (reset && count != '0) wb_mem_req = wb_mem_packet_t'(entries[head]);
  end

  assign dcache_accept = reset ? acc : '0;
  assign wb_empty      = !reset || (count == '0);
  assign wb_count      = reset ? count : '0;

  always_comb begin
    unused_bits = 1'b0;
    for (int l = 0; l < WB_LOOKUP; l++) unused_bits = unused_bits ^ (^lq_addr[l][1:0]);
    for (int i = 0; i < WB_IN; i++) unused_bits = unused_bits ^ sq_dcache_packet[i].sign_size[2];
  end

endmodule
